// File: rtl/jk_pkg.sv
// jk_pkg: JK op encodings, sequencer states and expected next-state helper
package jk_pkg;
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, REJECT} state_t;
  function automatic logic jk_next(input logic q, input logic [1:0] op);
    return op == OP_HOLD ? q : op == OP_RST ? 1'b0 : op == OP_SET ? 1'b1 : op == OP_TGL ? ~q : q;
  endfunction
endpackage

// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if: req_valid/ready/idx/op handshake, done_valid/id/q/err completion and ff_j/k/en/q bank pins; slave = arbiter, master = requesters plus bank
interface jk_bank_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_FF = 8,
  parameter int IDX_W = 3
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid, req_ready;
  logic [NUM_REQ*IDX_W-1:0] req_idx;
  logic [NUM_REQ*2-1:0] req_op;
  logic [NUM_FF-1:0] ff_j, ff_k, ff_en, ff_q;
  logic done_valid, done_q, done_err;
  logic [ID_W-1:0] done_id;
  modport master(
    output req_valid, req_idx, req_op, ff_q,
    input req_ready, ff_j, ff_k, ff_en, done_valid, done_id, done_q, done_err
  );
  modport slave(
    input req_valid, req_idx, req_op, ff_q,
    output req_ready, ff_j, ff_k, ff_en, done_valid, done_id, done_q, done_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr (req in, ptr in, one-hot gnt out, encoded win out)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    win
);
  int j;
  always_comb begin
    gnt = '0;
    win = '0;
    j = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (req[ID_W'(j)]) win = ID_W'(j);
    end
    if (req != '0) gnt[win] = 1'b1;
  end
endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin sequencer sharing a JK flop bank (clk, clear sync reset, bus slave: req handshake in, ff_j/k/en out, ff_q in, done completion out)
module jk_bank_arbiter import jk_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int NUM_FF = 8,
  parameter int IDX_W = 3,
  parameter int SETTLE_CYC = 1
) (
  input logic clk,
  input logic clear,
  jk_bank_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int NX = 1 << IDX_W;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, win_q, win_d, done_id_q, done_id_d, win;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0] idx_q, idx_d, idx_in;
  logic [1:0] op_q, op_d, op_in;
  logic prev_q, prev_d, done_valid_q, done_valid_d, done_q_q, done_q_d, done_err_q, done_err_d;
  logic [3:0] cnt_q, cnt_d;
  logic [NUM_FF-1:0] ff_j_q, ff_j_d, ff_k_q, ff_k_d, ff_en_q, ff_en_d;
  logic [NX-1:0] q_ext;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req(bus.req_valid), .ptr(ptr_q), .gnt(gnt), .win(win));
  assign q_ext = NX'(bus.ff_q);
  assign bus.req_ready = state_q == IDLE && !clear ? gnt : '0;
  assign bus.ff_j = ff_j_q;
  assign bus.ff_k = ff_k_q;
  assign bus.ff_en = ff_en_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_id = done_id_q;
  assign bus.done_q = done_q_q;
  assign bus.done_err = done_err_q;
  always_comb begin
    idx_in = '0;
    op_in = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (win == ID_W'(r)) begin
        idx_in = bus.req_idx[r*IDX_W +: IDX_W];
        op_in = bus.req_op[r*2 +: 2];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    idx_d = idx_q;
    op_d = op_q;
    prev_d = prev_q;
    cnt_d = cnt_q;
    ff_j_d = '0;
    ff_k_d = '0;
    ff_en_d = '0;
    done_valid_d = 1'b0;
    done_id_d = '0;
    done_q_d = 1'b0;
    done_err_d = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid != '0) begin
        win_d = win;
        idx_d = idx_in;
        op_d = op_in;
        prev_d = q_ext[idx_in];
        ptr_d = int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1;
        if (int'(idx_in) >= NUM_FF) begin
          state_d = REJECT;
          done_valid_d = 1'b1;
          done_err_d = 1'b1;
          done_id_d = win;
        end else begin
          state_d = DRIVE;
          ff_en_d = NUM_FF'(NX'(1) << idx_in);
          ff_j_d = op_in[1] ? ff_en_d : '0;
          ff_k_d = op_in[0] ? ff_en_d : '0;
        end
      end
      DRIVE: begin
        state_d = SETTLE;
        cnt_d = 4'(SETTLE_CYC - 1);
      end
      SETTLE: if (cnt_q == '0) begin
        state_d = SAMPLE;
        done_valid_d = 1'b1;
        done_id_d = win_q;
        done_q_d = q_ext[idx_q];
        done_err_d = q_ext[idx_q] != jk_next(prev_q, op_q);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      idx_q <= '0;
      op_q <= '0;
      prev_q <= 1'b0;
      cnt_q <= '0;
      ff_j_q <= '0;
      ff_k_q <= '0;
      ff_en_q <= '0;
      done_valid_q <= 1'b0;
      done_id_q <= '0;
      done_q_q <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      idx_q <= idx_d;
      op_q <= op_d;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      ff_j_q <= ff_j_d;
      ff_k_q <= ff_k_d;
      ff_en_q <= ff_en_d;
      done_valid_q <= done_valid_d;
      done_id_q <= done_id_d;
      done_q_q <= done_q_d;
      done_err_q <= done_err_d;
    end
  end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed scoreboard bench with a behavioural master-slave JK bank
module tb_jk_bank_arbiter;
  localparam int NR = 4;
  localparam int NF = 6;
  localparam int IW = 3;
  typedef struct {
    int id;
    int q;
    int err;
  } exp_t;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t e;
  logic [NF-1:0] m_q = '0;
  logic [NF-1:0] s_q = '0;
  logic [NF-1:0] stuck = '0;
  int t2_op[4] = '{2, 3, 3, 1};
  int t2_q[4] = '{1, 0, 1, 0};
  int t3_q[8] = '{1, 1, 0, 0, 1, 0, 0, 0};
  always #5 clk = ~clk;
  jk_bank_arbiter_if #(.NUM_REQ(NR), .NUM_FF(NF), .IDX_W(IW)) bus ();
  jk_bank_arbiter #(.NUM_REQ(NR), .NUM_FF(NF), .IDX_W(IW), .SETTLE_CYC(1)) dut (
    .clk(clk),
    .clear(clear),
    .bus(bus)
  );
  always @(posedge clk)
    for (int i = 0; i < NF; i++)
      if (bus.ff_en[i])
        m_q[i] <= bus.ff_j[i] && bus.ff_k[i] ? ~m_q[i] : bus.ff_j[i] ? 1'b1 : bus.ff_k[i] ? 1'b0 : m_q[i];
  always @(negedge clk) s_q <= m_q;
  assign bus.ff_q = s_q & ~stuck;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", int'(bus.done_valid), 0);
      else begin
        e = sb.pop_front();
        chk("done_id", int'(bus.done_id), e.id);
        chk("done_q", int'(bus.done_q), e.q);
        chk("done_err", int'(bus.done_err), e.err);
      end
    end
  end
  task automatic req(input int r, input int idx, input int op);
    bus.req_idx[r*IW +: IW] = IW'(idx);
    bus.req_op[r*2 +: 2] = 2'(op);
    bus.req_valid[r] = 1'b1;
  endtask
  task automatic grab(input logic [NR-1:0] exp, input string nm);
    int t = 0;
    #1;
    while (bus.req_ready == '0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk(nm, int'(bus.req_ready), int'(exp));
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = '0;
    bus.req_idx = '0;
    bus.req_op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_ff_en", int'(bus.ff_en), 0);
    chk("rst_ff_j", int'(bus.ff_j), 0);
    chk("rst_ff_k", int'(bus.ff_k), 0);
    chk("rst_done_valid", int'(bus.done_valid), 0);
    chk("rst_done_id", int'(bus.done_id), 0);
    chk("rst_done_q", int'(bus.done_q), 0);
    chk("rst_done_err", int'(bus.done_err), 0);
    @(negedge clk);
    clear = 1'b0;
    sb.push_back(exp_t'{0, 1, 0});
    req(0, 2, 2);
    grab(4'b0001, "t1_grant");
    bus.req_valid = '0;
    chk("t1_ff_en", int'(bus.ff_en), 6'b000100);
    chk("t1_ff_j", int'(bus.ff_j), 6'b000100);
    chk("t1_ff_k", int'(bus.ff_k), 0);
    @(posedge clk);
    #1;
    chk("t1_done_early", int'(bus.done_valid), 0);
    @(posedge clk);
    #1;
    chk("t1_done_latency", int'(bus.done_valid), 1);
    drain();
    for (int k = 0; k < 4; k++) begin
      sb.push_back(exp_t'{3, t2_q[k], 0});
      req(3, 5, t2_op[k]);
      grab(4'b1000, "t2_grant");
      bus.req_valid = '0;
      drain();
    end
    req(0, 0, 2);
    req(1, 1, 3);
    req(2, 2, 1);
    req(3, 3, 0);
    for (int k = 0; k < 8; k++) begin
      grab(NR'(1 << (k % 4)), "t3_grant");
      sb.push_back(exp_t'{k % 4, t3_q[k], 0});
      if (k == 7) bus.req_valid = '0;
    end
    drain();
    sb.push_back(exp_t'{1, 0, 1});
    req(1, 7, 2);
    grab(4'b0010, "t4_grant");
    bus.req_valid = '0;
    chk("t4_ff_en", int'(bus.ff_en), 0);
    chk("t4_done_next", int'(bus.done_valid), 1);
    drain();
    req(2, 4, 2);
    grab(4'b0100, "t5_grant");
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_clr_done_valid", int'(bus.done_valid), 0);
    chk("t5_clr_ff_en", int'(bus.ff_en), 0);
    chk("t5_clr_ff_j", int'(bus.ff_j), 0);
    chk("t5_clr_ff_k", int'(bus.ff_k), 0);
    chk("t5_clr_done_q", int'(bus.done_q), 0);
    chk("t5_clr_done_err", int'(bus.done_err), 0);
    clear = 1'b0;
    @(negedge clk);
    req(2, 4, 3);
    req(3, 1, 2);
    grab(4'b0100, "t5_ptr_reset_grant");
    sb.push_back(exp_t'{2, 0, 0});
    grab(4'b1000, "t5_second_grant");
    sb.push_back(exp_t'{3, 1, 0});
    bus.req_valid = '0;
    drain();
    stuck = 6'b001000;
    sb.push_back(exp_t'{0, 0, 1});
    req(0, 3, 2);
    grab(4'b0001, "t6_grant");
    bus.req_valid = '0;
    drain();
    stuck = '0;
    sb.push_back(exp_t'{0, 1, 0});
    req(0, 3, 0);
    grab(4'b0001, "t7_grant");
    bus.req_valid = '0;
    chk("t7_hold_ff_en", int'(bus.ff_en), 6'b001000);
    chk("t7_hold_ff_j", int'(bus.ff_j), 0);
    chk("t7_hold_ff_k", int'(bus.ff_k), 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
